// File: rtl/uvma_udma_ctrl_dp_in_mc_chkr_pkg.sv
// ----------------------------------------------------------------------------
// uvma_udma_ctrl_dp_in_mc_chkr_pkg
// Shared types for the uDMA datapath-in multi-channel protocol checker:
//   ch_state_e   per-channel handshake monitor state
//   err_code_e   violation codes; a lower value means higher reporting priority
//   SIZE_*       datasize encoding carried on the size bus
// ----------------------------------------------------------------------------
package uvma_udma_ctrl_dp_in_mc_chkr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,  // no request outstanding
      ST_WAIT    = 2'd1,  // valid seen without ready, payload latched
      ST_EXPIRED = 2'd2   // stall timeout already reported for this episode
   } ch_state_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_DROP     = 3'd1,
      ERR_DATA_CHG = 3'd2,
      ERR_SIZE_CHG = 3'd3,
      ERR_SIZE_ILL = 3'd4,
      ERR_TIMEOUT  = 3'd5
   } err_code_e;

   localparam logic [1:0] SIZE_BYTE    = 2'd0;
   localparam logic [1:0] SIZE_HALF    = 2'd1;
   localparam logic [1:0] SIZE_WORD    = 2'd2;
   localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

   function automatic logic size_is_legal(input logic [1:0] s);
      return s != SIZE_ILLEGAL;
   endfunction

endpackage

// File: rtl/uvma_udma_ctrl_dp_in_mc_chkr_if.sv
// ----------------------------------------------------------------------------
// uvma_udma_ctrl_dp_in_mc_chkr_if
// Bundle of the monitored uDMA datapath-in channels.
//   valid [NUM_CH]          per-channel request valid
//   ready [NUM_CH]          per-channel grant
//   data  [NUM_CH*DATA_W]   channel i at [i*DATA_W +: DATA_W]
//   size  [NUM_CH*2]        channel i at [i*2 +: 2]
// master drives the bundle, slave (the checker) only observes it.
// ----------------------------------------------------------------------------
interface uvma_udma_ctrl_dp_in_mc_chkr_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]        valid;
   logic [NUM_CH-1:0]        ready;
   logic [NUM_CH*DATA_W-1:0] data;
   logic [NUM_CH*2-1:0]      size;

   modport master (output valid, ready, data, size);
   modport slave  (input  valid, ready, data, size);
endinterface

// File: rtl/uvma_udma_ctrl_dp_in_ch_mon.sv
// ----------------------------------------------------------------------------
// uvma_udma_ctrl_dp_in_ch_mon
// Single-channel handshake monitor: tracks one valid/ready episode, checks
// payload stability, illegal size, dropped requests and stall timeout, and
// counts completed handshakes.
//   clk, reset_n   rising-edge clock, synchronous active-low reset
//   enable         checking enable; low forces IDLE and freezes the counter
//   clr            clears counter and sticky flag
//   valid, ready   channel handshake
//   data, size     channel payload
//   err_code       combinational code of the cycle being evaluated
//   err_pulse      registered one-cycle violation pulse
//   err_sticky     registered sticky violation flag
//   xfer_cnt       saturating count of completed handshakes
// ----------------------------------------------------------------------------
module uvma_udma_ctrl_dp_in_ch_mon
   import uvma_udma_ctrl_dp_in_mc_chkr_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STALL_MAX = 1024,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              clr,
   input  logic              valid,
   input  logic              ready,
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        size,
   output err_code_e         err_code,
   output logic              err_pulse,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam int STALL_W = $clog2(STALL_MAX + 1);

   ch_state_e          state_q, state_d;
   logic [DATA_W-1:0]  data_q;
   logic [1:0]         size_q;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               in_episode;
   logic               stall_hit;
   logic               latch_en;
   logic               err_hit;

   // stall_q holds the number of stalled cycles already seen in this episode,
   // so the cycle being evaluated is the STALL_MAX-th one when it equals
   // STALL_MAX-1.
   assign in_episode = (state_q != ST_IDLE);
   assign stall_hit  = (state_q == ST_WAIT) && valid && !ready &&
                       (stall_q == STALL_W'(STALL_MAX - 1));
   assign latch_en   = enable && (state_q == ST_IDLE) && valid && !ready;
   assign err_hit    = (err_code != ERR_NONE);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid && !ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (!valid || ready) state_d = ST_IDLE;
               else if (stall_hit)  state_d = ST_EXPIRED;
            end
            ST_EXPIRED: begin
               if (!valid || ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Violation decode; the if-chain order is the reporting priority, lowest
   // code first. DROP needs valid low, all others need valid high.
   always_comb begin
      err_code = ERR_NONE;
      if (enable) begin
         if (in_episode && !valid)                    err_code = ERR_DROP;
         else if (valid) begin
            if (in_episode && (data != data_q))       err_code = ERR_DATA_CHG;
            else if (in_episode && (size != size_q))  err_code = ERR_SIZE_CHG;
            else if (!size_is_legal(size))            err_code = ERR_SIZE_ILL;
            else if (stall_hit)                       err_code = ERR_TIMEOUT;
         end
      end
   end

   // Stall counter: starts at 1 on the cycle that opens the episode and stops
   // advancing once the episode has expired.
   always_comb begin
      stall_d = stall_q;
      if (!enable || (state_d == ST_IDLE)) stall_d = '0;
      else if (state_q == ST_IDLE)         stall_d = STALL_W'(1);
      else if (state_q == ST_WAIT)         stall_d = stall_q + STALL_W'(1);
   end

   // Datapath: payload latch, stall counter, registered status, counter
   // NOTE: the payload latch is reset too, so post-reset compares never see X
   // even though it is only consulted once an episode is open.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q     <= '0;
         size_q     <= '0;
         stall_q    <= '0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
         xfer_cnt   <= '0;
      end else begin
         if (latch_en) begin
            data_q <= data;
            size_q <= size;
         end
         stall_q   <= stall_d;
         err_pulse <= err_hit;
         // A violation in the clear cycle still sets the flag.
         err_sticky <= err_hit | (err_sticky & ~clr);
         if (clr)
            xfer_cnt <= '0;
         else if (enable && valid && ready && (xfer_cnt != {CNT_W{1'b1}}))
            xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uvma_udma_ctrl_dp_in_mc_chkr.sv
// ----------------------------------------------------------------------------
// uvma_udma_ctrl_dp_in_mc_chkr
// Multi-channel uDMA datapath-in protocol checker. One channel monitor per
// channel plus capture of the first violation since reset or clear.
//   clk, reset_n   rising-edge clock, synchronous active-low reset
//   enable         checking enable
//   clr            clears counters, sticky flags and first-error capture
//   bus            monitored channels (slave modport)
//   err_pulse      per-channel one-cycle violation pulse
//   err_sticky     per-channel sticky violation flag
//   first_ch       channel of the first captured violation
//   first_code     code of the first captured violation
//   first_vld      first_ch/first_code hold a capture
//   xfer_cnt       per-channel saturating handshake counters, CNT_W each
// ----------------------------------------------------------------------------
module uvma_udma_ctrl_dp_in_mc_chkr
   import uvma_udma_ctrl_dp_in_mc_chkr_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 32,
   parameter int STALL_MAX = 1024,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      clr,
   uvma_udma_ctrl_dp_in_mc_chkr_if.slave bus,
   output logic [NUM_CH-1:0]         err_pulse,
   output logic [NUM_CH-1:0]         err_sticky,
   output logic [3:0]                first_ch,
   output err_code_e                 first_code,
   output logic                      first_vld,
   output logic [NUM_CH*CNT_W-1:0]   xfer_cnt
);

   err_code_e  ch_code [NUM_CH];
   logic       any_err;
   logic [3:0] sel_ch;
   err_code_e  sel_code;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      uvma_udma_ctrl_dp_in_ch_mon #(
         .DATA_W    (DATA_W),
         .STALL_MAX (STALL_MAX),
         .CNT_W     (CNT_W)
      ) u_mon (
         .clk        (clk),
         .reset_n    (reset_n),
         .enable     (enable),
         .clr        (clr),
         .valid      (bus.valid[g]),
         .ready      (bus.ready[g]),
         .data       (bus.data[g*DATA_W +: DATA_W]),
         .size       (bus.size[g*2 +: 2]),
         .err_code   (ch_code[g]),
         .err_pulse  (err_pulse[g]),
         .err_sticky (err_sticky[g]),
         .xfer_cnt   (xfer_cnt[g*CNT_W +: CNT_W])
      );
   end

   // Lowest-index erroring channel: scan downwards so the last hit wins.
   always_comb begin
      any_err  = 1'b0;
      sel_ch   = '0;
      sel_code = ERR_NONE;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_code[i] != ERR_NONE) begin
            any_err  = 1'b1;
            sel_ch   = 4'(i);
            sel_code = ch_code[i];
         end
      end
   end

   // First-error capture; a violation in the clear cycle re-arms the capture
   // with itself instead of being lost.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         first_vld  <= 1'b0;
         first_ch   <= '0;
         first_code <= ERR_NONE;
      end else if ((clr || !first_vld) && any_err) begin
         first_vld  <= 1'b1;
         first_ch   <= sel_ch;
         first_code <= sel_code;
      end else if (clr) begin
         first_vld  <= 1'b0;
         first_ch   <= '0;
         first_code <= ERR_NONE;
      end
   end

endmodule

// File: tb/tb_uvma_udma_ctrl_dp_in_mc_chkr.sv
module tb_uvma_udma_ctrl_dp_in_mc_chkr;

   localparam int NUM_CH    = 4;
   localparam int DATA_W    = 32;
   localparam int STALL_MAX = 8;
   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic                    clk;
   logic                    reset_n;
   logic                    enable;
   logic                    clr;
   logic [NUM_CH-1:0]       err_pulse;
   logic [NUM_CH-1:0]       err_sticky;
   logic [3:0]              first_ch;
   logic [2:0]              first_code;
   logic                    first_vld;
   logic [NUM_CH*CNT_W-1:0] xfer_cnt;

   int total = 0;
   int bad   = 0;

   uvma_udma_ctrl_dp_in_mc_chkr_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   uvma_udma_ctrl_dp_in_mc_chkr #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .STALL_MAX(STALL_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .clr        (clr),
      .bus        (bus),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .first_ch   (first_ch),
      .first_code (first_code),
      .first_vld  (first_vld),
      .xfer_cnt   (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // A channel is "in an episode" from the first stalled cycle until the
   // request completes, disappears or checking is disabled.
   bit                m_ep  [NUM_CH];
   logic [DATA_W-1:0] m_hd  [NUM_CH];
   logic [1:0]        m_hs  [NUM_CH];
   int                m_run [NUM_CH];
   bit                m_to  [NUM_CH];

   logic [NUM_CH-1:0] e_pulse;
   logic [NUM_CH-1:0] e_sticky;
   int                e_cnt [NUM_CH];
   bit                e_fvld;
   int                e_fch;
   int                e_fcode;

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_ep[c] = 0; m_hd[c] = '0; m_hs[c] = '0; m_run[c] = 0; m_to[c] = 0;
         e_cnt[c] = 0;
      end
      e_pulse = '0; e_sticky = '0; e_fvld = 0; e_fch = 0; e_fcode = 0;
   endtask

   // Predict the outputs produced by the coming edge, then advance one cycle.
   task automatic clock_cycle();
      int code [NUM_CH];
      int low;
      if (!reset_n) begin
         model_reset();
      end else begin
         low = -1;
         for (int c = 0; c < NUM_CH; c++) begin
            bit v, r;
            logic [DATA_W-1:0] d;
            logic [1:0] s;
            v = bus.valid[c];
            r = bus.ready[c];
            d = bus.data[c*DATA_W +: DATA_W];
            s = bus.size[c*2 +: 2];
            code[c] = 0;
            if (enable) begin
               if (m_ep[c] && !v) code[c] = 1;
               else if (v) begin
                  if (m_ep[c] && d !== m_hd[c])      code[c] = 2;
                  else if (m_ep[c] && s !== m_hs[c]) code[c] = 3;
                  else if (s == 2'd3)                code[c] = 4;
                  else if (m_ep[c] && !r && !m_to[c] && (m_run[c] + 1 == STALL_MAX))
                     code[c] = 5;
               end
               if (v && !r) begin
                  if (!m_ep[c]) begin
                     m_ep[c] = 1; m_hd[c] = d; m_hs[c] = s; m_run[c] = 1; m_to[c] = 0;
                  end else begin
                     m_run[c]++;
                     if (m_run[c] == STALL_MAX) m_to[c] = 1;
                  end
               end else begin
                  m_ep[c] = 0; m_run[c] = 0; m_to[c] = 0;
               end
            end else begin
               m_ep[c] = 0; m_run[c] = 0; m_to[c] = 0;
            end
            if (clr) e_cnt[c] = 0;
            else if (enable && v && r && e_cnt[c] < CNT_MAX) e_cnt[c]++;
            e_pulse[c] = (code[c] != 0);
            if (code[c] != 0 && low < 0) low = c;
         end
         e_sticky = clr ? e_pulse : (e_sticky | e_pulse);
         if ((clr || !e_fvld) && low >= 0) begin
            e_fvld = 1; e_fch = low; e_fcode = code[low];
         end else if (clr) begin
            e_fvld = 0; e_fch = 0; e_fcode = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_ch(input int c, input bit v, input bit r,
                         input logic [DATA_W-1:0] d, input logic [1:0] s);
      bus.valid[c] = v;
      bus.ready[c] = r;
      bus.data[c*DATA_W +: DATA_W] = d;
      bus.size[c*2 +: 2] = s;
   endtask

   task automatic all_idle();
      bus.valid = '0;
      bus.ready = '0;
      bus.data  = '0;
      bus.size  = '0;
   endtask

   task automatic clear_pulse();
      clr = 1'b1;
      clock_cycle();
      clr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b1; clr = 1'b0;
      all_idle();
      clock_cycle();
      clock_cycle();
      total++;
      if (err_pulse !== '0 || err_sticky !== '0) begin
         bad++; $display("FAIL reset_err: pulse=%b sticky=%b want 0", err_pulse, err_sticky);
      end
      total++;
      if (first_vld !== 1'b0 || first_ch !== 4'd0 || first_code !== 3'd0) begin
         bad++; $display("FAIL reset_first: vld=%b ch=%0d code=%0d want 0", first_vld, first_ch, first_code);
      end
      total++;
      if (xfer_cnt !== '0) begin
         bad++; $display("FAIL reset_cnt: got %h want 0", xfer_cnt);
      end
      reset_n = 1'b1;
      clock_cycle();
   endtask

   task automatic test_handshake_wait();
      all_idle();
      clear_pulse();
      for (int k = 0; k < 3; k++) begin
         set_ch(0, 1, 0, 32'hA5A5_A5A5, 2'd2);
         clock_cycle();
         total++;
         if (err_pulse !== '0) begin
            bad++; $display("FAIL hs_stall_pulse: cycle %0d got %b want 0", k, err_pulse);
         end
      end
      set_ch(0, 1, 1, 32'hA5A5_A5A5, 2'd2);
      clock_cycle();
      set_ch(0, 0, 0, 32'h0, 2'd0);
      total++;
      if (err_pulse !== '0 || first_vld !== 1'b0) begin
         bad++; $display("FAIL hs_done_err: pulse=%b first_vld=%b want 0", err_pulse, first_vld);
      end
      total++;
      if (xfer_cnt[0 +: CNT_W] !== 4'd1) begin
         bad++; $display("FAIL hs_cnt: got %0d want 1", xfer_cnt[0 +: CNT_W]);
      end
      clock_cycle();
   endtask

   task automatic test_drop();
      all_idle();
      clear_pulse();
      set_ch(2, 1, 0, 32'hDEAD_0002, 2'd0);
      clock_cycle();
      set_ch(2, 0, 0, 32'hDEAD_0002, 2'd0);
      clock_cycle();
      total++;
      if (err_pulse !== 4'b0100) begin
         bad++; $display("FAIL drop_pulse: got %b want 0100", err_pulse);
      end
      total++;
      if (first_vld !== 1'b1 || first_ch !== 4'd2 || first_code !== 3'd1) begin
         bad++; $display("FAIL drop_first: vld=%b ch=%0d code=%0d want 1/2/1", first_vld, first_ch, first_code);
      end
      clock_cycle();
      total++;
      if (err_pulse !== '0 || err_sticky !== 4'b0100) begin
         bad++; $display("FAIL drop_after: pulse=%b sticky=%b want 0000/0100", err_pulse, err_sticky);
      end
   endtask

   task automatic test_timeout();
      int pulses;
      all_idle();
      clear_pulse();
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         set_ch(1, 1, 0, 32'h1234_5678, 2'd1);
         clock_cycle();
         if (err_pulse[1]) pulses++;
         total++;
         if (err_pulse[1] !== (k == STALL_MAX)) begin
            bad++; $display("FAIL timeout_pulse: stall %0d got %b want %b", k, err_pulse[1], k == STALL_MAX);
         end
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL timeout_count: got %0d pulses want 1", pulses);
      end
      total++;
      if (first_vld !== 1'b1 || first_ch !== 4'd1 || first_code !== 3'd5) begin
         bad++; $display("FAIL timeout_first: vld=%b ch=%0d code=%0d want 1/1/5", first_vld, first_ch, first_code);
      end
      set_ch(1, 1, 1, 32'h1234_5678, 2'd1);
      clock_cycle();
      set_ch(1, 0, 0, 32'h0, 2'd0);
      clock_cycle();
      total++;
      if (err_pulse !== '0) begin
         bad++; $display("FAIL timeout_release: got %b want 0", err_pulse);
      end
   endtask

   task automatic test_data_chg();
      all_idle();
      clear_pulse();
      set_ch(1, 1, 0, 32'h1111_1111, 2'd2);
      set_ch(3, 1, 0, 32'h3333_3333, 2'd2);
      clock_cycle();
      set_ch(1, 1, 0, 32'h1111_1112, 2'd2);
      set_ch(3, 1, 0, 32'h3333_3334, 2'd2);
      clock_cycle();
      total++;
      if (err_pulse !== 4'b1010) begin
         bad++; $display("FAIL dchg_pulse: got %b want 1010", err_pulse);
      end
      total++;
      if (first_vld !== 1'b1 || first_ch !== 4'd1 || first_code !== 3'd2) begin
         bad++; $display("FAIL dchg_first: vld=%b ch=%0d code=%0d want 1/1/2", first_vld, first_ch, first_code);
      end
      // Size change while stalled on ch3 only
      set_ch(1, 0, 0, 32'h0, 2'd0);
      set_ch(3, 1, 0, 32'h3333_3333, 2'd1);
      clock_cycle();
      total++;
      if (err_pulse !== 4'b1010 || first_code !== 3'd2) begin
         bad++; $display("FAIL dchg_follow: pulse=%b code=%0d want 1010/2", err_pulse, first_code);
      end
      all_idle();
      clock_cycle();
      clock_cycle();
   endtask

   task automatic test_saturate();
      all_idle();
      clear_pulse();
      for (int k = 0; k < 20; k++) begin
         set_ch(0, 1, 1, 32'(k), 2'd2);
         clock_cycle();
      end
      total++;
      if (xfer_cnt[0 +: CNT_W] !== 4'd15) begin
         bad++; $display("FAIL sat_cnt: got %0d want 15", xfer_cnt[0 +: CNT_W]);
      end
      total++;
      if (err_pulse !== '0) begin
         bad++; $display("FAIL sat_err: got %b want 0", err_pulse);
      end
      all_idle();
      clear_pulse();
      total++;
      if (xfer_cnt !== '0) begin
         bad++; $display("FAIL sat_clr: got %h want 0", xfer_cnt);
      end
   endtask

   task automatic test_enable();
      all_idle();
      clear_pulse();
      set_ch(0, 1, 0, 32'hCAFE_0000, 2'd2);
      clock_cycle();
      clock_cycle();
      enable = 1'b0;
      set_ch(0, 0, 0, 32'h0, 2'd0);
      clock_cycle();
      set_ch(0, 1, 1, 32'h0, 2'd3);
      clock_cycle();
      clock_cycle();
      total++;
      if (err_pulse !== '0 || xfer_cnt[0 +: CNT_W] !== 4'd0) begin
         bad++; $display("FAIL en_off: pulse=%b cnt=%0d want 0/0", err_pulse, xfer_cnt[0 +: CNT_W]);
      end
      // Stall 5, disable one cycle, then stall again: timeout restarts counting.
      enable = 1'b1;
      set_ch(0, 1, 0, 32'hCAFE_0001, 2'd2);
      for (int k = 0; k < 5; k++) clock_cycle();
      enable = 1'b0;
      clock_cycle();
      enable = 1'b1;
      for (int k = 1; k <= STALL_MAX; k++) begin
         clock_cycle();
         total++;
         if (err_pulse[0] !== (k == STALL_MAX)) begin
            bad++; $display("FAIL en_restart: stall %0d got %b want %b", k, err_pulse[0], k == STALL_MAX);
         end
      end
      set_ch(0, 0, 0, 32'h0, 2'd0);
      clock_cycle();
      total++;
      if (err_pulse !== 4'b0001 || first_code !== 3'd5) begin
         bad++; $display("FAIL en_drop: pulse=%b first_code=%0d want 0001/5", err_pulse, first_code);
      end
      clock_cycle();
   endtask

   task automatic test_reset_mid();
      all_idle();
      set_ch(0, 1, 0, 32'h5555_AAAA, 2'd0);
      clock_cycle();
      clock_cycle();
      reset_n = 1'b0;
      clock_cycle();
      total++;
      if (err_pulse !== '0 || err_sticky !== '0 || first_vld !== 1'b0 || xfer_cnt !== '0) begin
         bad++; $display("FAIL rst_mid: pulse=%b sticky=%b vld=%b cnt=%h want 0", err_pulse, err_sticky, first_vld, xfer_cnt);
      end
      reset_n = 1'b1;
      set_ch(0, 0, 0, 32'h0, 2'd0);
      clock_cycle();
      total++;
      if (err_pulse !== '0 || first_vld !== 1'b0) begin
         bad++; $display("FAIL rst_nodrop: pulse=%b vld=%b want 0/0", err_pulse, first_vld);
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] rd [NUM_CH];
      logic [1:0]        rs [NUM_CH];
      int vp, rp;
      for (int c = 0; c < NUM_CH; c++) begin
         rd[c] = $urandom; rs[c] = 2'($urandom_range(0, 2));
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         // Alternate stall-heavy and handshake-heavy phases to reach timeouts.
         if ((cyc / 100) % 2 == 0) begin vp = 95; rp = 5; end
         else begin vp = 70; rp = 50; end
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 99) < 6) rd[c] = $urandom;
            if ($urandom_range(0, 99) < 4) rs[c] = 2'($urandom_range(0, 3));
            set_ch(c, $urandom_range(0, 99) < vp, $urandom_range(0, 99) < rp, rd[c], rs[c]);
         end
         enable  = ($urandom_range(0, 99) < 97);
         clr     = ($urandom_range(0, 99) < 3);
         reset_n = ($urandom_range(0, 199) != 0);
         clock_cycle();
         total++;
         if (err_pulse !== e_pulse || err_sticky !== e_sticky) begin
            bad++; $display("FAIL rnd_err: cyc %0d pulse=%b sticky=%b want %b/%b", cyc, err_pulse, err_sticky, e_pulse, e_sticky);
         end
         total++;
         if (first_vld !== e_fvld || first_ch !== 4'(e_fch) || first_code !== 3'(e_fcode)) begin
            bad++; $display("FAIL rnd_first: cyc %0d vld=%b ch=%0d code=%0d want %b/%0d/%0d", cyc, first_vld, first_ch, first_code, e_fvld, e_fch, e_fcode);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            total++;
            if (xfer_cnt[c*CNT_W +: CNT_W] !== CNT_W'(e_cnt[c])) begin
               bad++; $display("FAIL rnd_cnt: cyc %0d ch %0d got %0d want %0d", cyc, c, xfer_cnt[c*CNT_W +: CNT_W], e_cnt[c]);
            end
         end
      end
      reset_n = 1'b1; enable = 1'b1; clr = 1'b0;
      all_idle();
      clock_cycle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_handshake_wait();
      test_drop();
      test_timeout();
      test_data_chg();
      test_saturate();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
